// File: rtl/cmd_arbiter_if.sv
// cmd_arbiter_if: command-source, cmd_proc and response signals around the arbiter
interface cmd_arbiter_if;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_UART;
  logic [15:0] cmd_tour;
  logic        cmd_rdy_tour;
  logic        tour_last;
  logic        tour_active;
  logic        clr_tour;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        resp_vld;
  logic [1:0]  gnt;
  logic        timeout;
  modport slave (
    input  cmd_UART, cmd_rdy_UART, cmd_tour, cmd_rdy_tour, tour_last, tour_active,
    input  clr_cmd_rdy, send_resp,
    output clr_UART, clr_tour, cmd, cmd_rdy, resp, resp_vld, gnt, timeout
  );
  modport master (
    output cmd_UART, cmd_rdy_UART, cmd_tour, cmd_rdy_tour, tour_last, tour_active,
    output clr_cmd_rdy, send_resp,
    input  clr_UART, clr_tour, cmd, cmd_rdy, resp, resp_vld, gnt, timeout
  );
endinterface

// File: rtl/cmd_arbiter.sv
// cmd_arbiter: round-robin arbiter of UART and tour commands into cmd_proc with response/timeout generation
module cmd_arbiter #(
  parameter int TMO_CYC = 50_000_000
) (
  input logic clk,
  input logic rst,
  cmd_arbiter_if.slave arb_if
);
  localparam int CW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;
  state_t state_q, state_d;
  logic [15:0] cmd_q, cmd_d;
  logic [1:0] gnt_q, gnt_d;
  logic [7:0] resp_q, resp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last_q, last_d;
  logic clr_uart_q, clr_uart_d;
  logic clr_tour_q, clr_tour_d;
  logic tmo_q, tmo_d;
  logic fav_tour_q, fav_tour_d;
  logic req_u, req_t, pick_t, expire;
  logic [7:0] ok_resp;
  // UART is locked out during a tour; on contention the source not served last wins
  always_comb begin
    req_u = arb_if.cmd_rdy_UART & ~arb_if.tour_active;
    req_t = arb_if.cmd_rdy_tour;
    pick_t = req_t & (~req_u | fav_tour_q);
    ok_resp = (gnt_q[1] & ~last_q) ? 8'h5A : 8'hA5;
    expire = cnt_q == CW'(TMO_CYC - 1);
  end
  // next-state and datapath updates for the grant/issue/busy/response sequence
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    gnt_d = gnt_q;
    resp_d = resp_q;
    cnt_d = cnt_q;
    last_d = last_q;
    clr_uart_d = 1'b0;
    clr_tour_d = 1'b0;
    tmo_d = tmo_q;
    fav_tour_d = fav_tour_q;
    case (state_q)
      IDLE: if (req_u | req_t) begin
        state_d = ISSUE;
        cmd_d = pick_t ? arb_if.cmd_tour : arb_if.cmd_UART;
        gnt_d = pick_t ? 2'b10 : 2'b01;
        last_d = pick_t & arb_if.tour_last;
        clr_uart_d = ~pick_t;
        clr_tour_d = pick_t;
        tmo_d = 1'b0;
      end
      ISSUE: if (arb_if.clr_cmd_rdy) begin
        state_d = arb_if.send_resp ? RESP : BUSY;
        cnt_d = '0;
        resp_d = arb_if.send_resp ? ok_resp : resp_q;
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (arb_if.send_resp | expire) begin
          state_d = RESP;
          resp_d = arb_if.send_resp ? ok_resp : 8'hEE;
          tmo_d = ~arb_if.send_resp;
        end
      end
      RESP: begin
        state_d = IDLE;
        gnt_d = 2'b00;
        fav_tour_d = gnt_q[0];
        tmo_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q <= '0;
      gnt_q <= '0;
      resp_q <= '0;
      cnt_q <= '0;
      last_q <= 1'b0;
      clr_uart_q <= 1'b0;
      clr_tour_q <= 1'b0;
      tmo_q <= 1'b0;
      fav_tour_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      gnt_q <= gnt_d;
      resp_q <= resp_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      clr_uart_q <= clr_uart_d;
      clr_tour_q <= clr_tour_d;
      tmo_q <= tmo_d;
      fav_tour_q <= fav_tour_d;
    end
  end
  assign arb_if.cmd = cmd_q;
  assign arb_if.cmd_rdy = state_q == ISSUE;
  assign arb_if.clr_UART = clr_uart_q;
  assign arb_if.clr_tour = clr_tour_q;
  assign arb_if.resp = resp_q;
  assign arb_if.resp_vld = state_q == RESP;
  assign arb_if.gnt = gnt_q;
  assign arb_if.timeout = (state_q == RESP) & tmo_q;
endmodule

// File: tb/tb_cmd_arbiter.sv
// tb_cmd_arbiter: scoreboard bench for cmd_arbiter with TMO_CYC=8
module tb_cmd_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [17:0] exp_g[$];
  logic [8:0] exp_r[$];
  logic prev_vld = 1'b0;
  logic [17:0] g;
  logic [8:0] r;
  cmd_arbiter_if bus();
  cmd_arbiter #(.TMO_CYC(8)) dut (.clk(clk), .rst(rst), .arb_if(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask
  task automatic expect_cmd(input logic [1:0] eg, input logic [15:0] ec, input logic [7:0] er, input logic et);
    exp_g.push_back({eg, ec});
    exp_r.push_back({et, er});
  endtask
  task automatic check_zero(input string name);
    check(name, {bus.cmd, bus.cmd_rdy, bus.resp, bus.resp_vld, bus.gnt, bus.clr_UART, bus.clr_tour, bus.timeout}, 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_zero("reset_outputs");
    rst = 1'b0;
  endtask
  task automatic grant_wait(input bit uart);
    int n = 0;
    while (!(uart ? bus.clr_UART : bus.clr_tour) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(uart ? "grant_uart_seen" : "grant_tour_seen", uart ? bus.clr_UART : bus.clr_tour, 1);
    if (uart) bus.cmd_rdy_UART = 1'b0;
    else bus.cmd_rdy_tour = 1'b0;
  endtask
  task automatic serve(input int delay);
    int n = 0;
    while (!bus.cmd_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_rdy_seen", bus.cmd_rdy, 1);
    bus.send_resp = 1'b1;
    @(negedge clk);
    bus.send_resp = 1'b0;
    @(negedge clk);
    check("cmd_rdy_hold", bus.cmd_rdy, 1);
    bus.clr_cmd_rdy = 1'b1;
    bus.send_resp = delay == 0;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0;
    check("cmd_rdy_drop", bus.cmd_rdy, 0);
    if (delay > 0) begin
      repeat (delay - 1) @(negedge clk);
      bus.send_resp = 1'b1;
      @(negedge clk);
      bus.send_resp = 1'b0;
    end else if (delay < 0) begin
      n = 1;
      while (!bus.resp_vld && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("timeout_latency", n, 9);
    end
    @(negedge clk);
    check("gnt_idle", bus.gnt, 0);
    @(negedge clk);
  endtask
  initial begin
    bus.cmd_UART = '0;
    bus.cmd_rdy_UART = 1'b0;
    bus.cmd_tour = '0;
    bus.cmd_rdy_tour = 1'b0;
    bus.tour_last = 1'b0;
    bus.tour_active = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0;
    do_reset();
    expect_cmd(2'b01, 16'h2001, 8'hA5, 1'b0);
    bus.cmd_UART = 16'h2001;
    bus.cmd_rdy_UART = 1'b1;
    grant_wait(1);
    serve(3);
    do_reset();
    for (int k = 0; k < 2; k++) begin
      expect_cmd(2'b01, 16'h1111 + 16'(k), 8'hA5, 1'b0);
      expect_cmd(2'b10, 16'h2222 + 16'(k), 8'h5A, 1'b0);
      bus.cmd_UART = 16'h1111 + 16'(k);
      bus.cmd_tour = 16'h2222 + 16'(k);
      bus.cmd_rdy_UART = 1'b1;
      bus.cmd_rdy_tour = 1'b1;
      grant_wait(1);
      serve(0);
      grant_wait(0);
      serve(2);
    end
    bus.tour_active = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      expect_cmd(2'b10, 16'h3000 + 16'(k), (k == 24) ? 8'hA5 : 8'h5A, 1'b0);
      bus.cmd_tour = 16'h3000 + 16'(k);
      bus.tour_last = k == 24;
      bus.cmd_rdy_tour = 1'b1;
      grant_wait(0);
      bus.tour_last = 1'b0;
      serve(k % 3);
    end
    expect_cmd(2'b10, 16'h6666, 8'h5A, 1'b0);
    bus.cmd_UART = 16'h5555;
    bus.cmd_tour = 16'h6666;
    bus.cmd_rdy_UART = 1'b1;
    bus.cmd_rdy_tour = 1'b1;
    grant_wait(0);
    serve(1);
    repeat (4) @(negedge clk);
    check("uart_blocked", bus.gnt, 0);
    expect_cmd(2'b01, 16'h5555, 8'hA5, 1'b0);
    bus.tour_active = 1'b0;
    grant_wait(1);
    serve(2);
    expect_cmd(2'b01, 16'h7777, 8'hEE, 1'b1);
    bus.cmd_UART = 16'h7777;
    bus.cmd_rdy_UART = 1'b1;
    grant_wait(1);
    serve(-1);
    expect_cmd(2'b01, 16'h8888, 8'hA5, 1'b0);
    bus.cmd_UART = 16'h8888;
    bus.cmd_rdy_UART = 1'b1;
    grant_wait(1);
    bus.tour_active = 1'b1;
    serve(8);
    bus.tour_active = 1'b0;
    exp_g.push_back({2'b01, 16'h9999});
    bus.cmd_UART = 16'h9999;
    bus.cmd_rdy_UART = 1'b1;
    grant_wait(1);
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("reset_in_busy");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("idle_after_reset", {bus.gnt, bus.resp_vld}, 0);
    expect_cmd(2'b01, 16'hAAAA, 8'hA5, 1'b0);
    bus.cmd_UART = 16'hAAAA;
    bus.cmd_rdy_UART = 1'b1;
    grant_wait(1);
    serve(1);
    repeat (5) @(negedge clk);
    check("queues_drained", exp_g.size() + exp_r.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (bus.clr_UART || bus.clr_tour) begin
      if (exp_g.size() == 0) check("grant_unexpected", {bus.clr_tour, bus.clr_UART}, 0);
      else begin
        g = exp_g.pop_front();
        check("grant_gnt", bus.gnt, g[17:16]);
        check("grant_clr", {bus.clr_tour, bus.clr_UART}, g[17:16]);
        check("grant_cmd", bus.cmd, g[15:0]);
        check("grant_cmd_rdy", bus.cmd_rdy, 1);
      end
    end
    if (bus.resp_vld) begin
      check("resp_vld_pulse", prev_vld, 0);
      if (exp_r.size() == 0) check("resp_unexpected", bus.resp_vld, 0);
      else begin
        r = exp_r.pop_front();
        check("resp_byte", bus.resp, r[7:0]);
        check("resp_timeout", bus.timeout, r[8]);
      end
    end else if (bus.timeout) check("timeout_without_vld", bus.timeout, 0);
    prev_vld = bus.resp_vld;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1);
  end
endmodule
